// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, data width, width helper.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_e;

    // $clog2 that never returns 0, so single-value counters still get one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after i_ptr, wrapping around.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_id,
    output logic               o_any
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_idx = ID_W'((32'(i_ptr) + i) % NUM_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources, with
// start sequencing, optional inter-frame gap and acknowledge-timeout recovery.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]               o_req_ready,
    output logic [UART_DATA_W-1:0]           o_tx_data,
    output logic                             o_tx_start,
    input  logic                             i_tx_busy,
    output logic [clog2_min1(NUM_REQ)-1:0]   o_grant_id,
    output logic                             o_active,
    output logic                             o_timeout_err
);

    localparam int unsigned ID_W  = clog2_min1(NUM_REQ);
    localparam int unsigned ACK_W = clog2_min1(ACK_TIMEOUT + 1);
    localparam int unsigned GAP_W = clog2_min1(GAP_CYCLES + 1);

    state_e                 r_state, w_state_next;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_grant_id;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic [ACK_W-1:0]       r_ack_cnt, w_ack_cnt_next, w_ack_inc;
    logic [GAP_W-1:0]       r_gap_cnt, w_gap_cnt_next;
    logic                   r_timeout_err, w_timeout;
    logic                   w_grant;

    logic [NUM_REQ-1:0]     w_arb_gnt;
    logic [ID_W-1:0]        w_arb_id;
    logic                   w_arb_any;
    logic [UART_DATA_W-1:0] w_arb_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req    (i_req_valid),
        .i_ptr    (r_rr_ptr),
        .o_gnt    (w_arb_gnt),
        .o_gnt_id (w_arb_id),
        .o_any    (w_arb_any)
    );

    always_comb begin
        w_arb_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_arb_gnt[k]) begin
                w_arb_data = i_req_data[k*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    assign w_ack_inc = r_ack_cnt + ACK_W'(1);

    always_comb begin
        w_state_next   = r_state;
        w_ack_cnt_next = r_ack_cnt;
        w_gap_cnt_next = r_gap_cnt;
        w_timeout      = 1'b0;
        w_grant        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_any) begin
                    w_grant      = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_state_next   = S_WAIT_ACK;
                w_ack_cnt_next = '0;
            end
            S_WAIT_ACK: begin
                // Busy already high here (e.g. left over across a reset) counts as the ack.
                if (i_tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end else if (w_ack_inc == ACK_W'(ACK_TIMEOUT)) begin
                    w_timeout      = 1'b1;
                    w_gap_cnt_next = '0;
                    w_state_next   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    w_ack_cnt_next = w_ack_inc;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_gap_cnt_next = '0;
                    w_state_next   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= ID_W'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_tx_data     <= '0;
            r_ack_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ack_cnt     <= w_ack_cnt_next;
            r_gap_cnt     <= w_gap_cnt_next;
            r_timeout_err <= w_timeout;
            if (w_grant) begin
                r_tx_data  <= w_arb_data;
                r_grant_id <= w_arb_id;
                r_rr_ptr   <= w_arb_id;
            end
        end
    end

    // Ready and start are gated by reset so neither can fire in a cycle that is being discarded.
    assign o_req_ready   = (w_grant && !i_rst) ? w_arb_gnt : '0;
    assign o_tx_start    = (r_state == S_START) && !i_rst;
    assign o_tx_data     = r_tx_data;
    assign o_grant_id    = r_grant_id;
    assign o_active      = (r_state != S_IDLE);
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requests, simple UART busy model, monitor checks.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned GAP_CYCLES  = 2;
    localparam int unsigned ACK_TIMEOUT = 16;
    localparam int unsigned BUSY_LEN    = 4;
    localparam int unsigned SPACING     = 3 + BUSY_LEN + GAP_CYCLES;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [3:0]   i_req_valid;
    logic [31:0]  i_req_data;
    logic [3:0]   o_req_ready;
    logic [7:0]   o_tx_data;
    logic         o_tx_start;
    logic         i_tx_busy;
    logic [1:0]   o_grant_id;
    logic         o_active;
    logic         o_timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .GAP_CYCLES  (GAP_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .i_req_data    (i_req_data),
        .o_req_ready   (o_req_ready),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .i_tx_busy     (i_tx_busy),
        .o_grant_id    (o_grant_id),
        .o_active      (o_active),
        .o_timeout_err (o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pend[4]  = '{0, 0, 0, 0};
    int q_rdy[$];
    int q_tx[$];
    int last_rdy   = 0;
    int last_start = 0;
    int sp_last    = -1;
    bit spacing_en = 1'b0;
    bit uart_en    = 1'b1;
    int n_to       = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit all_idle();
        return (pend[0] == 0) && (pend[1] == 0) && (pend[2] == 0) && (pend[3] == 0)
            && (q_rdy.size() == 0) && (q_tx.size() == 0) && !o_active && !i_tx_busy;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge i_clk);
            n++;
            done = all_idle();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_idle: still active after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!i_tx_busy && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check({name, "_busy"}, 32'(i_tx_busy), 32'd1);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_ready"},   32'(o_req_ready),   32'd0);
        check({name, "_data"},    32'(o_tx_data),     32'd0);
        check({name, "_start"},   32'(o_tx_start),    32'd0);
        check({name, "_grant"},   32'(o_grant_id),    32'd0);
        check({name, "_active"},  32'(o_active),      32'd0);
        check({name, "_timeout"}, 32'(o_timeout_err), 32'd0);
    endtask

    // Requester driver: valid follows the pending count, which drops on each ready pulse.
    initial begin : driver
        logic [3:0] rdy_s;
        forever begin
            @(negedge i_clk);
            rdy_s = o_req_ready;
            @(posedge i_clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (rdy_s[k] && pend[k] > 0) pend[k]--;
                i_req_valid[k] = (pend[k] > 0);
            end
        end
    end

    // UART model: busy for BUSY_LEN cycles starting the cycle after a start pulse.
    initial begin : uart_model
        int busy_left;
        bit seen;
        busy_left = 0;
        i_tx_busy = 1'b0;
        forever begin
            @(negedge i_clk);
            seen = uart_en && o_tx_start;
            @(posedge i_clk);
            #1;
            if (seen) busy_left = BUSY_LEN;
            else if (busy_left > 0) busy_left--;
            i_tx_busy = (busy_left > 0);
        end
    end

    initial begin : monitor
        int e;
        forever begin
            @(negedge i_clk);
            if (o_req_ready != 4'd0) begin
                if (q_rdy.size() == 0) begin
                    check("unexpected_ready", 32'(o_req_ready), 32'd0);
                end else begin
                    e = q_rdy.pop_front();
                    check("ready_onehot", 32'(o_req_ready), 32'd1 << e);
                end
                if (spacing_en && sp_last >= 0) check("grant_spacing", 32'(cyc - sp_last), SPACING);
                sp_last  = cyc;
                last_rdy = cyc;
            end
            if (o_tx_start) begin
                check("start_latency", 32'(cyc - last_rdy), 32'd1);
                if (q_tx.size() == 0) begin
                    check("unexpected_start", 32'(o_tx_start), 32'd0);
                end else begin
                    e = q_tx.pop_front();
                    check("tx_data", 32'(o_tx_data), 32'(e & 255));
                    check("grant_id", 32'(o_grant_id), 32'(e >> 8));
                end
                last_start = cyc;
            end
            if (o_timeout_err) begin
                n_to++;
                check("timeout_latency", 32'(cyc - last_start), 32'(1 + ACK_TIMEOUT));
            end
        end
    end

    task automatic expect_frame(input int id, input int data);
        q_rdy.push_back(id);
        q_tx.push_back(id * 256 + data);
    endtask

    initial begin : stimulus
        i_rst       = 1'b1;
        i_req_valid = 4'd0;
        i_req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_values("reset");
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        @(negedge i_clk);

        // Single request from requester 2.
        i_req_data[23:16] = 8'h5A;
        expect_frame(2, 'h5A);
        pend[2] = 1;
        wait_idle("single");
        check("hold_data", 32'(o_tx_data), 32'h5A);
        check("hold_grant", 32'(o_grant_id), 32'd2);
        i_req_data[23:16] = 8'h32;

        // Contention: pointer sits at 2, so order is 3,0,1,2,3.
        spacing_en = 1'b1;
        sp_last    = -1;
        expect_frame(3, 'h43);
        expect_frame(0, 'h10);
        expect_frame(1, 'h21);
        expect_frame(2, 'h32);
        expect_frame(3, 'h43);
        pend = '{1, 1, 1, 2};
        wait_idle("contention");
        spacing_en = 1'b0;

        // Requester 1 pulses valid for one cycle mid-frame: must be ignored.
        expect_frame(0, 'h10);
        pend[0] = 1;
        wait_busy("withdrawn");
        @(posedge i_clk);
        #2 i_req_valid[1] = 1'b1;
        wait_idle("withdrawn");

        // UART never acknowledges: timeout, then a normal frame still goes through.
        uart_en = 1'b0;
        expect_frame(2, 'h32);
        pend[2] = 1;
        wait_idle("timeout");
        uart_en = 1'b1;
        expect_frame(1, 'h21);
        pend[1] = 1;
        wait_idle("after_timeout");

        // Reset during WAIT_DONE, then requesters 0 and 3 together: 0 wins first.
        expect_frame(3, 'h43);
        pend[3] = 1;
        wait_busy("midframe");
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        @(negedge i_clk);
        check_reset_values("midframe_reset");
        expect_frame(0, 'h10);
        expect_frame(3, 'h43);
        pend[0] = 1;
        pend[3] = 1;
        wait_idle("post_reset");

        check("timeout_count", 32'(n_to), 32'd1);
        check("queues_drained", 32'(q_rdy.size() + q_tx.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
